// File: rtl/bus_resp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bus_resp_pkg
//  Purpose  : Shared types and constants for the bus acknowledge responder:
//             the responder FSM state encoding and the default data width.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package bus_resp_pkg;

    localparam int DW_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,    // queue empty, nothing to acknowledge
        WAIT = 2'd1,    // head request counting down its delay
        ACK  = 2'd2     // bus_ack high for exactly this cycle
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bus_resp_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : bus_resp_fifo
//  Purpose  : Synchronous in-order request queue with occupancy count.
//             The head entry is presented combinationally on pop_data.
//  Ports    : clk       - clock, rising edge
//             reset     - asynchronous reset, active-high (clears pointers/count)
//             push      - write push_data at the tail (caller ensures not full)
//             push_data - DW-bit entry to enqueue
//             pop       - drop the head entry (caller ensures not empty)
//             pop_data  - current head entry
//             count     - number of stored entries, 0..DEPTH
//  Revision : 1.0 - initial release
// ============================================================================
module bus_resp_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [DW-1:0]                push_data,
    input  logic                         pop,
    output logic [DW-1:0]                pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    // DEPTH is a power of two, so the pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr];
    assign count    = cnt;

endmodule
`default_nettype wire

// File: rtl/bus_ack_responder.sv
`default_nettype none
// ============================================================================
//  Module   : bus_ack_responder
//  Purpose  : Queues single-cycle bus requests and answers each one with a
//             single-cycle acknowledge carrying its payload, no earlier than
//             ACK_DELAY cycles after the request and ACK_DELAY cycles after
//             the previous acknowledge.
//  Ports    : clk       - clock, rising edge
//             reset     - asynchronous reset, active-high
//             bus_req   - request pulse
//             bus_data  - request payload (valid with bus_req)
//             bus_ack   - acknowledge pulse
//             ack_data  - acknowledged payload, 0 when bus_ack is low
//             pending   - queued, un-acked requests
//             overflow  - sticky: a request was dropped on a full queue
//             proto_err - sticky: bus_req held high two cycles in a row
//  Options  : BUS_ACK_RESPONDER_PROTO_CHK_EN - enables the proto_err checker;
//             when undefined proto_err is constant 0.
//  Revision : 1.0 - initial release
// ============================================================================
module bus_ack_responder
    import bus_resp_pkg::*;
#(
    parameter int DW        = DW_DEFAULT,
    parameter int DEPTH     = 4,
    parameter int ACK_DELAY = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         bus_req,
    input  logic [DW-1:0]                bus_data,
    output logic                         bus_ack,
    output logic [DW-1:0]                ack_data,
    output logic [$clog2(DEPTH+1)-1:0]   pending,
    output logic                         overflow,
    output logic                         proto_err
);

    localparam int             CW       = $clog2(DEPTH+1);
    localparam logic [CW-1:0]  FULL     = CW'(DEPTH);
    // WAIT lasts ACK_DELAY-1 cycles; the count is loaded on entry.
    localparam logic [3:0]     CNT_LOAD = 4'(ACK_DELAY - 1);

    state_t        state;
    state_t        state_next;
    logic [3:0]    cnt;
    logic [3:0]    cnt_next;
    logic          push;
    logic          pop;
    logic [DW-1:0] head_data;

    // Fullness is judged on the pre-edge count: no bypass through a pop.
    assign push = bus_req && (pending != FULL);

    bus_resp_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (bus_data),
        .pop       (pop),
        .pop_data  (head_data),
        .count     (pending)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (push) begin
                    // A one-cycle delay has no countdown phase at all.
                    if (ACK_DELAY == 1) begin
                        state_next = ACK;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt <= 4'd1) begin
                    state_next = ACK;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ACK: begin
                pop = 1'b1;
                // Queue still non-empty after this pop (counting a same-cycle push)?
                if ((pending > CW'(1)) || push) begin
                    if (ACK_DELAY == 1) begin
                        state_next = ACK;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_LOAD;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus_ack  = (state == ACK);
    assign ack_data = bus_ack ? head_data : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (bus_req && (pending == FULL)) begin
            overflow <= 1'b1;
        end
    end

`ifdef BUS_ACK_RESPONDER_PROTO_CHK_EN
    logic req_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_d     <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            req_d <= bus_req;
            if (bus_req && req_d) begin
                proto_err <= 1'b1;
            end
        end
    end
`else
    assign proto_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_ack_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_ack_responder
//  Purpose  : Self-checking bench for bus_ack_responder. Directed scenarios
//             use fixed expected cycles/payloads; a randomized run is checked
//             against an arithmetic model of ack times and queue occupancy.
//             A second instance with ACK_DELAY=8 exercises queue-full drops.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bus_ack_responder;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int DLY   = 2;
    localparam int PW    = $clog2(DEPTH+1);

`ifdef BUS_ACK_RESPONDER_PROTO_CHK_EN
    localparam logic PERR_EN = 1'b1;
`else
    localparam logic PERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          bus_req;
    logic [DW-1:0] bus_data;
    logic          bus_ack;
    logic [DW-1:0] ack_data;
    logic [PW-1:0] pending;
    logic          overflow;
    logic          proto_err;

    logic          s_bus_ack;
    logic [DW-1:0] s_ack_data;
    logic [PW-1:0] s_pending;
    logic          s_overflow;
    logic          s_proto_err;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [DW-1:0] d;
        int            ack;
    } ent_t;

    logic          seq_req  [64];
    logic [DW-1:0] seq_data [64];
    logic          obs_ack  [64];
    logic [DW-1:0] obs_data [64];
    logic [PW-1:0] obs_pend [64];
    logic          obs_ovf  [64];
    logic          obs_perr [64];
    logic          obs_sack [64];
    logic [DW-1:0] obs_sdata[64];
    logic [PW-1:0] obs_spend[64];
    logic          obs_sovf [64];

    always #5 clk = ~clk;

    bus_ack_responder #(.DW(DW), .DEPTH(DEPTH), .ACK_DELAY(DLY)) dut (
        .clk(clk), .reset(reset), .bus_req(bus_req), .bus_data(bus_data),
        .bus_ack(bus_ack), .ack_data(ack_data), .pending(pending),
        .overflow(overflow), .proto_err(proto_err)
    );

    bus_ack_responder #(.DW(DW), .DEPTH(DEPTH), .ACK_DELAY(8)) dut_slow (
        .clk(clk), .reset(reset), .bus_req(bus_req), .bus_data(bus_data),
        .bus_ack(s_bus_ack), .ack_data(s_ack_data), .pending(s_pending),
        .overflow(s_overflow), .proto_err(s_proto_err)
    );

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        bus_req  = 1'b0;
        bus_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_seq();
        for (int i = 0; i < 64; i++) begin
            seq_req[i]  = 1'b0;
            seq_data[i] = '0;
        end
    endtask

    // Cycle c: outputs observed at its negedge, then its inputs are driven.
    task automatic run_seq(input int n);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            obs_ack[c]   = bus_ack;
            obs_data[c]  = ack_data;
            obs_pend[c]  = pending;
            obs_ovf[c]   = overflow;
            obs_perr[c]  = proto_err;
            obs_sack[c]  = s_bus_ack;
            obs_sdata[c] = s_ack_data;
            obs_spend[c] = s_pending;
            obs_sovf[c]  = s_overflow;
            bus_req      = seq_req[c];
            bus_data     = seq_data[c];
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        bus_req  = 1'b0;
        bus_data = '0;
        #1 reset = 1'b1;
        #1;
        tests++;
        if ({bus_ack, ack_data, pending, overflow, proto_err} !== '0) begin
            fails++;
            $display("FAIL reset_state got ack=%b data=%h pend=%0d ovf=%b perr=%b exp all 0",
                     bus_ack, ack_data, pending, overflow, proto_err);
        end
        tests++;
        if ({s_bus_ack, s_ack_data, s_pending, s_overflow, s_proto_err} !== '0) begin
            fails++;
            $display("FAIL reset_state_slow got ack=%b pend=%0d exp 0", s_bus_ack, s_pending);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        clear_seq();
        seq_req[1]  = 1'b1;
        seq_data[1] = 32'hfeed;
        run_seq(6);
        for (int c = 1; c <= 6; c++) begin
            logic          e_ack;
            logic [DW-1:0] e_d;
            logic [PW-1:0] e_p;
            e_ack = (c == 3);
            e_d   = e_ack ? 32'hfeed : '0;
            e_p   = (c == 2 || c == 3) ? PW'(1) : PW'(0);
            tests++;
            if (obs_ack[c] !== e_ack || obs_data[c] !== e_d || obs_pend[c] !== e_p) begin
                fails++;
                $display("FAIL single c=%0d got ack=%b data=%h pend=%0d exp ack=%b data=%h pend=%0d",
                         c, obs_ack[c], obs_data[c], obs_pend[c], e_ack, e_d, e_p);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        clear_seq();
        for (int i = 1; i <= 3; i++) begin
            seq_req[i]  = 1'b1;
            seq_data[i] = DW'(i);
        end
        run_seq(10);
        for (int c = 1; c <= 10; c++) begin
            logic          e_ack;
            logic [DW-1:0] e_d;
            e_ack = (c == 3 || c == 5 || c == 7);
            e_d   = e_ack ? DW'((c - 1) / 2) : '0;
            tests++;
            if (obs_ack[c] !== e_ack || obs_data[c] !== e_d) begin
                fails++;
                $display("FAIL back_to_back c=%0d got ack=%b data=%h exp ack=%b data=%h",
                         c, obs_ack[c], obs_data[c], e_ack, e_d);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        clear_seq();
        for (int i = 1; i <= 5; i++) begin
            seq_req[i]  = 1'b1;
            seq_data[i] = DW'(9 + i);
        end
        run_seq(42);
        tests++;
        if (obs_spend[6] !== PW'(4) || obs_sovf[5] !== 1'b0 || obs_sovf[6] !== 1'b1) begin
            fails++;
            $display("FAIL overflow_full got pend=%0d ovf5=%b ovf6=%b exp pend=4 ovf5=0 ovf6=1",
                     obs_spend[6], obs_sovf[5], obs_sovf[6]);
        end
        for (int c = 1; c <= 42; c++) begin
            logic          e_ack;
            logic [DW-1:0] e_d;
            e_ack = (c == 9 || c == 17 || c == 25 || c == 33);
            e_d   = e_ack ? DW'(9 + (c - 1) / 8) : '0;
            tests++;
            if (obs_sack[c] !== e_ack || obs_sdata[c] !== e_d) begin
                fails++;
                $display("FAIL overflow_acks c=%0d got ack=%b data=%h exp ack=%b data=%h",
                         c, obs_sack[c], obs_sdata[c], e_ack, e_d);
            end
        end
    endtask

    task automatic test_full_ack_collision();
        do_reset();
        clear_seq();
        for (int i = 1; i <= 7; i++) begin
            seq_req[i]  = 1'b1;
            seq_data[i] = DW'(i);
        end
        run_seq(16);
        tests++;
        if (obs_pend[7] !== PW'(DEPTH) || obs_ack[7] !== 1'b1 || obs_ovf[7] !== 1'b0) begin
            fails++;
            $display("FAIL collision_pre got pend=%0d ack=%b ovf=%b exp pend=4 ack=1 ovf=0",
                     obs_pend[7], obs_ack[7], obs_ovf[7]);
        end
        tests++;
        if (obs_pend[8] !== PW'(DEPTH - 1) || obs_ovf[8] !== 1'b1) begin
            fails++;
            $display("FAIL collision_post got pend=%0d ovf=%b exp pend=3 ovf=1",
                     obs_pend[8], obs_ovf[8]);
        end
        for (int c = 1; c <= 16; c++) begin
            logic          e_ack;
            logic [DW-1:0] e_d;
            e_ack = (c >= 3 && c <= 13 && (c % 2) == 1);
            e_d   = e_ack ? DW'((c - 1) / 2) : '0;
            tests++;
            if (obs_ack[c] !== e_ack || obs_data[c] !== e_d) begin
                fails++;
                $display("FAIL collision_acks c=%0d got ack=%b data=%h exp ack=%b data=%h",
                         c, obs_ack[c], obs_data[c], e_ack, e_d);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        clear_seq();
        for (int i = 1; i <= 3; i++) begin
            seq_req[i]  = 1'b1;
            seq_data[i] = DW'(32'h100 + i);
        end
        run_seq(4);
        tests++;
        if (obs_pend[4] !== PW'(2) || obs_ack[4] !== 1'b0) begin
            fails++;
            $display("FAIL midwait_pre got pend=%0d ack=%b exp pend=2 ack=0", obs_pend[4], obs_ack[4]);
        end
        // Assert reset away from any clock edge; a request is held through it.
        #2;
        reset    = 1'b1;
        bus_req  = 1'b1;
        bus_data = 32'hdead;
        #1;
        tests++;
        if (bus_ack !== 1'b0 || pending !== PW'(0) || ack_data !== '0) begin
            fails++;
            $display("FAIL midwait_async got ack=%b pend=%0d data=%h exp 0 0 0", bus_ack, pending, ack_data);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        bus_req = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            tests++;
            if (bus_ack !== 1'b0 || pending !== PW'(0)) begin
                fails++;
                $display("FAIL midwait_after c=%0d got ack=%b pend=%0d exp ack=0 pend=0", c, bus_ack, pending);
            end
        end
    endtask

    task automatic test_proto();
        do_reset();
        clear_seq();
        seq_req[1]  = 1'b1;
        seq_data[1] = 32'ha1;
        seq_req[2]  = 1'b1;
        seq_data[2] = 32'ha2;
        run_seq(7);
        tests++;
        if (obs_perr[2] !== 1'b0 || obs_perr[3] !== PERR_EN) begin
            fails++;
            $display("FAIL proto_flag got c2=%b c3=%b exp c2=0 c3=%b", obs_perr[2], obs_perr[3], PERR_EN);
        end
        for (int c = 1; c <= 7; c++) begin
            logic          e_ack;
            logic [DW-1:0] e_d;
            e_ack = (c == 3 || c == 5);
            e_d   = (c == 3) ? 32'ha1 : (c == 5) ? 32'ha2 : '0;
            tests++;
            if (obs_ack[c] !== e_ack || obs_data[c] !== e_d) begin
                fails++;
                $display("FAIL proto_acks c=%0d got ack=%b data=%h exp ack=%b data=%h",
                         c, obs_ack[c], obs_data[c], e_ack, e_d);
            end
        end
    endtask

    // Model: each accepted request is acked at max(req+D, previous ack+D);
    // pending is the number of accepted requests whose ack cycle is not past.
    task automatic test_random(input int pct, input int n);
        ent_t q[$];
        int   last_ack = -1000;
        logic m_ovf    = 1'b0;
        logic m_perr   = 1'b0;
        logic prev     = 1'b0;
        do_reset();
        for (int c = 1; c <= n; c++) begin
            logic          e_ack;
            logic [DW-1:0] e_d;
            logic [PW-1:0] e_p;
            logic          r;
            logic [DW-1:0] d;
            @(negedge clk);
            while (q.size() > 0 && q[0].ack < c) void'(q.pop_front());
            e_ack = (q.size() > 0) && (q[0].ack == c);
            e_d   = e_ack ? q[0].d : '0;
            e_p   = PW'(q.size());
            tests++;
            if (bus_ack !== e_ack || ack_data !== e_d || pending !== e_p ||
                overflow !== m_ovf || proto_err !== m_perr) begin
                fails++;
                $display("FAIL random c=%0d got ack=%b data=%h pend=%0d ovf=%b perr=%b exp ack=%b data=%h pend=%0d ovf=%b perr=%b",
                         c, bus_ack, ack_data, pending, overflow, proto_err,
                         e_ack, e_d, e_p, m_ovf, m_perr);
            end
            r        = ($urandom_range(0, 99) < pct);
            d        = $urandom;
            bus_req  = r;
            bus_data = d;
            if (r) begin
                if (q.size() < DEPTH) begin
                    int a;
                    a = c + DLY;
                    if (last_ack + DLY > a) a = last_ack + DLY;
                    q.push_back('{d: d, ack: a});
                    last_ack = a;
                end else begin
                    m_ovf = 1'b1;
                end
                if (prev && PERR_EN) m_perr = 1'b1;
            end
            prev = r;
        end
        @(negedge clk);
        bus_req = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_ack_collision();
        test_reset_mid_wait();
        test_proto();
        test_random(30, 300);
        test_random(75, 300);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_ack_responder.md
BUS_ACK_RESPONDER -- requirements
Module: bus_ack_responder

Interface
REQ-001 The block SHALL have the parameter DW, default 32, setting the request/acknowledge data width.
REQ-002 The block SHALL have the parameter DEPTH, default 4, setting the number of queued requests (power of two, 2..16).
REQ-003 The block SHALL have the parameter ACK_DELAY, default 2, setting the minimum number of cycles from a request to its ack (1..15).
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock, rising edge active.
REQ-005 The block SHALL have the port reset, input, 1 bit: asynchronous reset, active-high.
REQ-006 The block SHALL have the port bus_req, input, 1 bit: single-cycle request pulse from the initiator.
REQ-007 The block SHALL have the port bus_data, input, DW bits: request payload, valid while bus_req is high.
REQ-008 The block SHALL have the port bus_ack, output, 1 bit: single-cycle acknowledge pulse.
REQ-009 The block SHALL have the port ack_data, output, DW bits: payload of the acknowledged request, valid while bus_ack is high and 0 otherwise.
REQ-010 The block SHALL have the port pending, output, $clog2(DEPTH+1) bits: number of queued, un-acked requests.
REQ-011 The block SHALL have the port overflow, output, 1 bit: sticky flag, set when a request is dropped.
REQ-012 The block SHALL have the port proto_err, output, 1 bit: sticky protocol-violation flag (see Configuration).

Function
REQ-013 At each rising clk edge with bus_req=1 and pending<DEPTH, the block SHALL push bus_data into an in-order queue.
REQ-014 A request arriving with pending==DEPTH SHALL be dropped and SHALL set overflow; full is judged on pre-edge pending, with no bypass even if an ack pops in the same cycle.
REQ-015 The FSM SHALL use the states IDLE (queue empty), WAIT (head counting down) and ACK (bus_ack high for one cycle).
REQ-016 Transitions SHALL be: IDLE->WAIT on push; WAIT->ACK when the countdown expires; ACK->WAIT if the queue is non-empty after the pop, else ACK->IDLE.
REQ-017 The ack for request k SHALL occur in cycle max(req_k + ACK_DELAY, ack_(k-1) + ACK_DELAY); for example, with ACK_DELAY=2, a request in cycle 1 gives bus_ack in cycle 3.
REQ-018 bus_ack SHALL never be high for two consecutive cycles unless ACK_DELAY==1.
REQ-019 The queue SHALL pop in the ACK cycle; pending SHALL reflect a push and a pop in the same cycle as a net change of zero.
REQ-020 Read/write pointers SHALL wrap modulo DEPTH; the countdown counter SHALL be 4 bits, with no wrap.
REQ-021 overflow SHALL remain set until reset.

Reset
REQ-022 On reset assertion, the block SHALL immediately force bus_ack=0, ack_data=0, pending=0, overflow=0, proto_err=0 and FSM=IDLE, and SHALL discard all queued requests.
REQ-023 A request coincident with the reset deassertion edge SHALL be ignored; the first sampled request is the one at the next rising edge.

Configuration
REQ-024 With BUS_ACK_RESPONDER_PROTO_CHK_EN defined, the block SHALL set proto_err when bus_req is high in two consecutive cycles (a non-pulse request); the second cycle is still treated as a request.
REQ-025 Without BUS_ACK_RESPONDER_PROTO_CHK_EN, proto_err SHALL be tied to 0 and no checker logic SHALL be present.

Structure
REQ-026 The package bus_resp_pkg SHALL hold the FSM state enum (IDLE/WAIT/ACK) and the DW default constant.
REQ-027 The queue SHALL be the sub-module bus_resp_fifo (synchronous FIFO with push/pop/count); the FSM and countdown SHALL stay in the top module.

Verification
REQ-028 A single bus_req in cycle 1 with bus_data=32'hfeed SHALL produce bus_ack only in cycle 3 with ack_data=32'hfeed, and pending 1 then 0.
REQ-029 With ACK_DELAY=2, requests in cycles 1, 2 and 3 (data 1, 2, 3) SHALL produce acks in cycles 3, 5 and 7 with data 1, 2, 3 in order.
REQ-030 With DEPTH=4, five requests in consecutive cycles SHALL leave pending=4, set overflow, and ack only the first four payloads.
REQ-031 A request that arrives in the same cycle as an ack while pending==DEPTH SHALL be dropped, with overflow=1 and pending=DEPTH-1 after the edge.
REQ-032 Reset asserted mid-WAIT with pending=2 SHALL give bus_ack=0 and pending=0 asynchronously, and SHALL produce no ack after reset release.
REQ-033 With the macro defined, bus_req high for two consecutive cycles SHALL set proto_err=1 and produce two acks; without the macro, the same stimulus SHALL keep proto_err=0.
